gpr_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the 32×32 GPR file. It shares the file's single write port between the in-order pipeline writeback stage and one long-latency requester (MDU/load-miss return path). Pipeline writeback has priority. A starvation counter forces a writeback bubble when the long-latency result has waited too long. A pending-destination scoreboard tells decode which registers are still awaiting a long-latency write.

---
 rtl/gpr_wb_arbiter.sv | 138 +++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: pipeline writeback has priority, a starvation guard protects the long-latency path.
// Optional pending-write scoreboard compiled in with `define GPR_WB_SCOREBOARD_EN.
module gpr_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic        ll_valid,
  input  logic [4:0]  ll_a3,
  input  logic [31:0] ll_wd,
  output logic        ll_ready,
  input  logic        ll_issue,
  input  logic [4:0]  ll_issue_a3,
  input  logic [4:0]  q_a1,
  input  logic [4:0]  q_a2,
  output logic        sb_busy1,
  output logic        sb_busy2,
  output logic        hold_req,
  output logic        rf_we,
  output logic [4:0]  rf_a3,
  output logic [31:0] rf_wd
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;
  logic             wb_act;
  logic             blocked;

  // A write to $0 never occupies the port, so it cannot block the long-latency result.
  assign wb_act   = wb_we && (wb_a3 != 5'd0);
  assign ll_ready = ll_valid && !wb_act;
  assign blocked  = ll_valid && !ll_ready;
  assign hold_req = hold_q;

  always_comb begin
    rf_we = 1'b0;
    rf_a3 = 5'd0;
    rf_wd = 32'd0;
    if (wb_act) begin
      rf_we = 1'b1;
      rf_a3 = wb_a3;
      rf_wd = wb_wd;
    end else if (ll_valid) begin
      rf_we = 1'b1;
      rf_a3 = ll_a3;
      rf_wd = ll_wd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        hold_d = 1'b0;
        if (blocked) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
          hold_d  = (MAX_C == CNT_W'(1));
        end
      end
      ST_WAIT: begin
        if (blocked) begin
          if (cnt_q != MAX_C) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          hold_d = hold_q || (cnt_d == MAX_C);
        end else begin
          // Either accepted or the requester withdrew; both end the wait.
          state_d = ST_IDLE;
          cnt_d   = '0;
          hold_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

`ifdef GPR_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Set is applied after clear so a re-issue to the same register stays pending.
  always_comb begin
    busy_d = busy_q;
    if (ll_ready && (ll_a3 != 5'd0)) begin
      busy_d[ll_a3] = 1'b0;
    end
    if (ll_issue && (ll_issue_a3 != 5'd0)) begin
      busy_d[ll_issue_a3] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign sb_busy1 = busy_q[q_a1] || (ll_issue && (ll_issue_a3 == q_a1) && (q_a1 != 5'd0));
  assign sb_busy2 = busy_q[q_a2] || (ll_issue && (ll_issue_a3 == q_a2) && (q_a2 != 5'd0));
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{ll_issue, ll_issue_a3, q_a1, q_a2};
  assign sb_busy1 = 1'b0;
  assign sb_busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomised self-checking bench for gpr_wb_arbiter against a streak/array reference model.
module tb_gpr_wb_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef GPR_WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        ll_valid;
  logic [4:0]  ll_a3;
  logic [31:0] ll_wd;
  logic        ll_ready;
  logic        ll_issue;
  logic [4:0]  ll_issue_a3;
  logic [4:0]  q_a1, q_a2;
  logic        sb_busy1, sb_busy2, hold_req;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int checks = 0;
  int errors = 0;

  // Reference model: length of the current blocked streak and the set of pending registers.
  int streak = 0;
  bit busy_m [32];
  bit last_ready;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .Clk(clk), .Rst(rst),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .ll_valid(ll_valid), .ll_a3(ll_a3), .ll_wd(ll_wd), .ll_ready(ll_ready),
    .ll_issue(ll_issue), .ll_issue_a3(ll_issue_a3),
    .q_a1(q_a1), .q_a2(q_a2), .sb_busy1(sb_busy1), .sb_busy2(sb_busy2),
    .hold_req(hold_req), .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_busy(input logic [4:0] q);
    if (!SB_EN || q == 5'd0) return 1'b0;
    return busy_m[q] || (ll_issue && ll_issue_a3 == q);
  endfunction

  task automatic model_reset();
    streak = 0;
    foreach (busy_m[i]) busy_m[i] = 1'b0;
  endtask

  // Drive one cycle at the falling edge, check just after, then advance the model at the rising edge.
  task automatic applyStimulus(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                               input logic lv, input logic [4:0] la3, input logic [31:0] lwd,
                               input logic iss, input logic [4:0] ia3,
                               input logic [4:0] qa1, input logic [4:0] qa2);
    bit act, rdy;
    @(negedge clk);
    wb_we = we; wb_a3 = a3; wb_wd = wd;
    ll_valid = lv; ll_a3 = la3; ll_wd = lwd;
    ll_issue = iss; ll_issue_a3 = ia3;
    q_a1 = qa1; q_a2 = qa2;
    #1;
    act = we && (a3 != 5'd0);
    rdy = lv && !act;
    checkOutput("ll_ready", ll_ready, rdy);
    checkOutput("rf_we", rf_we, act || lv);
    checkOutput("rf_a3", rf_a3, act ? a3 : (lv ? la3 : 5'd0));
    checkOutput("rf_wd", rf_wd, act ? wd : (lv ? lwd : 32'd0));
    checkOutput("hold_req", hold_req, streak >= STARVE_MAX);
    checkOutput("sb_busy1", sb_busy1, model_busy(qa1));
    checkOutput("sb_busy2", sb_busy2, model_busy(qa2));
    @(posedge clk);
    last_ready = rdy;
    if (lv && !rdy) streak++;
    else streak = 0;
    if (SB_EN) begin
      if (rdy && la3 != 5'd0) busy_m[la3] = 1'b0;
      if (iss && ia3 != 5'd0) busy_m[ia3] = 1'b1;
    end
  endtask

  task automatic idle_cycle(input logic [4:0] qa1, input logic [4:0] qa2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, qa1, qa2);
  endtask

  initial begin
    logic        r_lv, r_we, r_iss;
    logic [4:0]  r_la3, r_a3, r_ia3;
    logic [31:0] r_lwd;

    rst = 1'b1;
    wb_we = 0; wb_a3 = 0; wb_wd = 0; ll_valid = 0; ll_a3 = 0; ll_wd = 0;
    ll_issue = 0; ll_issue_a3 = 0; q_a1 = 0; q_a2 = 0;
    model_reset();
    #12;
    checkOutput("reset_hold", hold_req, 1'b0);
    checkOutput("reset_rf_we", rf_we, 1'b0);
    checkOutput("reset_sb1", sb_busy1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle-port accept");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    idle_cycle(5'd5, 5'd0);

    $display("[TB] collision");
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd3, 5'd7);
    applyStimulus(1'b0, 5'd3, 32'h11, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd3, 5'd7);

    $display("[TB] starvation");
    for (int i = 0; i < STARVE_MAX; i++)
      applyStimulus(1'b1, 5'd2, 32'h100 + i, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd6, 5'd2);
    #1 checkOutput("starve_hold_up", hold_req, 1'b1);
    applyStimulus(1'b0, 5'd2, 32'h0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd6, 5'd2);
    #1 checkOutput("starve_hold_down", hold_req, 1'b0);

    $display("[TB] write to zero does not block");
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 5'd8, 5'd0);

    $display("[TB] scoreboard set-wins");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle_cycle(5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0);
    idle_cycle(5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd9, 5'd0);
    idle_cycle(5'd9, 5'd0);

    $display("[TB] async reset mid-wait");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0);
    for (int i = 0; i < STARVE_MAX + 1; i++)
      applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd4, 5'd0);
    #1 checkOutput("pre_reset_hold", hold_req, 1'b1);
    #1;
    rst = 1'b1;
    ll_valid = 1'b0;
    wb_we = 1'b0;
    model_reset();
    #1;
    checkOutput("async_rst_hold", hold_req, 1'b0);
    checkOutput("async_rst_sb1", sb_busy1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_ready = 1'b1;

    $display("[TB] random phase");
    r_lv = 0; r_la3 = 0; r_lwd = 0;
    for (int n = 0; n < 400; n++) begin
      // A result not yet accepted is held with stable destination and data.
      if (!(r_lv && !last_ready)) begin
        r_lv  = ($urandom_range(0, 2) != 0);
        r_la3 = 5'($urandom_range(0, 31));
        r_lwd = $urandom;
      end
      if (streak >= STARVE_MAX && $urandom_range(0, 7) != 0) r_we = 1'b0;
      else r_we = ($urandom_range(0, 3) != 0);
      r_a3  = 5'($urandom_range(0, 31));
      r_iss = ($urandom_range(0, 2) == 0);
      r_ia3 = 5'($urandom_range(0, 31));
      applyStimulus(r_we, r_a3, $urandom, r_lv, r_la3, r_lwd, r_iss, r_ia3,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
